// File: rtl/baby_pkg.sv
// Shared constants and types for the Manchester Baby store dump path.
package baby_pkg;

    localparam int WORD_W       = 32;
    localparam int STORE_DEPTH  = 32;
    localparam int STORE_ADDR_W = $clog2(STORE_DEPTH);
    localparam int BIT_IDX_W    = $clog2(WORD_W);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        SHIFT,
        FIN
    } dump_state_t;

endpackage

// File: rtl/baby_word_serialiser.sv
// Holds one store word and presents it LSB-first over a valid/ready bit handshake.
module baby_word_serialiser
    import baby_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 load,
    input  logic [WORD_W-1:0]    load_data,
    input  logic                 active,
    input  logic                 bit_ready,
    output logic                 bit_valid,
    output logic                 bit_data,
    output logic [BIT_IDX_W-1:0] bit_idx,
    output logic                 xfer,
    output logic                 word_end
);

    logic [WORD_W-1:0] shreg;

    assign bit_valid = active;
    assign xfer      = active && bit_ready;
    assign word_end  = xfer && (bit_idx == BIT_IDX_W'(WORD_W - 1));
    // Masked so the data line reads 0 whenever nothing is offered.
    assign bit_data  = active && shreg[0];

    // Shift register and bit position: clear beats load beats shift.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    // NOTE: the shift register is a small datapath register, so it is reset like any other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else if (clear) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else if (load) begin
            shreg   <= load_data;
            bit_idx <= '0;
        end else if (xfer) begin
            shreg   <= {1'b0, shreg[WORD_W-1:1]};
            bit_idx <= bit_idx + BIT_IDX_W'(1);
        end
    end

endmodule

// File: rtl/baby_store_dumper.sv
// Walks the 32x32 store line by line and streams it out in snapshot order.
module baby_store_dumper
    import baby_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd_en,
    output logic [STORE_ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0]       mem_rdata,
    output logic                    bit_valid,
    input  logic                    bit_ready,
    output logic                    bit_data,
    output logic [STORE_ADDR_W-1:0] bit_line,
    output logic [BIT_IDX_W-1:0]    bit_idx,
    output logic                    bit_last
);

    dump_state_t             state, state_nxt;
    logic [STORE_ADDR_W-1:0] line, line_nxt;
    logic                    xfer;
    logic                    word_end;
    logic                    final_line;

    assign final_line = (line == STORE_ADDR_W'(STORE_DEPTH - 1));

    // State and line counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            line  <= '0;
        end else begin
            state <= state_nxt;
            line  <= line_nxt;
        end
    end

    // Next-state and line sequencing; abort overrides everything, including a same-cycle transfer.
    // NOTE: every signal driven here gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        state_nxt = state;
        line_nxt  = line;
        if (abort) begin
            state_nxt = IDLE;
            line_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = READ;
                        line_nxt  = '0;
                    end
                end
                READ:  state_nxt = LOAD;
                LOAD:  state_nxt = SHIFT;
                SHIFT: begin
                    if (word_end) begin
                        if (final_line) begin
                            state_nxt = FIN;
                        end else begin
                            state_nxt = READ;
                            line_nxt  = line + STORE_ADDR_W'(1);
                        end
                    end
                end
                FIN: begin
                    state_nxt = IDLE;
                    line_nxt  = '0;
                end
                default: begin
                    state_nxt = IDLE;
                    line_nxt  = '0;
                end
            endcase
        end
    end

    // Status and store read port decode straight from the state register.
    assign busy      = (state == READ) || (state == LOAD) || (state == SHIFT);
    assign done      = (state == FIN);
    assign mem_rd_en = (state == READ);
    assign mem_addr  = line;
    assign bit_line  = line;
    assign bit_last  = bit_valid && final_line && (bit_idx == BIT_IDX_W'(WORD_W - 1));

    baby_word_serialiser u_serialiser (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (abort),
        .load      (state == LOAD),
        .load_data (mem_rdata),
        .active    (state == SHIFT),
        .bit_ready (bit_ready),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .bit_idx   (bit_idx),
        .xfer      (xfer),
        .word_end  (word_end)
    );

endmodule
